// File: rtl/pj_unidade_controle_pkg.sv
// pj_unidade_controle_pkg
//   Shared definitions for the MindFocus control unit: state encoding,
//   state width, default show time and the show-timer width helper.
package pj_unidade_controle_pkg;

    localparam int ST_W              = 4;
    localparam int MOSTRA_CICLOS_DEF = 1000;

    typedef enum logic [ST_W-1:0] {
        INICIAL    = 4'h0,
        PREPARA    = 4'h1,
        SEMENTE    = 4'h2,
        GERA       = 4'h3,
        REG_IDX    = 4'h4,
        MOSTRA     = 4'h5,
        ESPERA     = 4'h6,
        REGISTRA   = 4'h7,
        COMPARA    = 4'h8,
        ACERTO     = 4'h9,
        PROX_ITEM  = 4'hA,
        FIM_RODADA = 4'hB,
        AVANCA     = 4'hC,
        CHECA      = 4'hD,
        FIM        = 4'hE,
        INVALIDO   = 4'hF
    } estado_t;

    // Counter width for a modulus, never below one bit (MOSTRA_CICLOS may be 1).
    function automatic int largura_contador(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pj_unidade_controle_if.sv
// pj_unidade_controle_if
//   Control/status bundle between the control unit and the game datapath.
//   master : control unit (receives status, drives control strobes)
//   slave  : datapath side (drives status, receives control strobes)
//   Status : iniciar, jogada_feita, botao_igual_memoria, fim_e,
//            rodada_igual_final, indices_prontos, timeout
//   Control: zera_a/e/r/rod, zera_indices, zera_tempo, registra_r,
//            registra_indice, conta_a/e/rod, conta_tempo, sel_semente,
//            pronto, db_estado[3:0]
interface pj_unidade_controle_if;
    import pj_unidade_controle_pkg::*;

    logic            iniciar;
    logic            jogada_feita;
    logic            botao_igual_memoria;
    logic            fim_e;
    logic            rodada_igual_final;
    logic            indices_prontos;
    logic            timeout;

    logic            zera_a;
    logic            zera_e;
    logic            zera_r;
    logic            zera_rod;
    logic            zera_indices;
    logic            zera_tempo;
    logic            registra_r;
    logic            registra_indice;
    logic            conta_a;
    logic            conta_e;
    logic            conta_rod;
    logic            conta_tempo;
    logic            sel_semente;
    logic            pronto;
    logic [ST_W-1:0] db_estado;

    modport master (
        input  iniciar, jogada_feita, botao_igual_memoria, fim_e,
               rodada_igual_final, indices_prontos, timeout,
        output zera_a, zera_e, zera_r, zera_rod, zera_indices, zera_tempo,
               registra_r, registra_indice, conta_a, conta_e, conta_rod,
               conta_tempo, sel_semente, pronto, db_estado
    );

    modport slave (
        output iniciar, jogada_feita, botao_igual_memoria, fim_e,
               rodada_igual_final, indices_prontos, timeout,
        input  zera_a, zera_e, zera_r, zera_rod, zera_indices, zera_tempo,
               registra_r, registra_indice, conta_a, conta_e, conta_rod,
               conta_tempo, sel_semente, pronto, db_estado
    );

endinterface

// File: rtl/pj_unidade_controle_contador_m.sv
// pj_unidade_controle_contador_m
//   Modulo-M up counter used as the stimulus show timer.
//   i_clock  : clock, rising edge
//   i_reset  : asynchronous active-high reset
//   i_zera_s : synchronous clear (wins over i_conta)
//   i_conta  : count enable
//   o_fim    : count is at terminal value M-1
module pj_unidade_controle_contador_m #(
    parameter int M = 4,
    parameter int N = (M > 1) ? $clog2(M) : 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_zera_s,
    input  logic i_conta,
    output logic o_fim
);

    localparam logic [N-1:0] TERMINAL = N'(M - 1);

    logic [N-1:0] r_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_q <= '0;
        end else if (i_zera_s) begin
            r_q <= '0;
        end else if (i_conta) begin
            r_q <= (r_q == TERMINAL) ? '0 : r_q + 1'b1;
        end
    end

    assign o_fim = (r_q == TERMINAL);

endmodule

// File: rtl/pj_unidade_controle.sv
// pj_unidade_controle
//   Moore FSM sequencing the MindFocus datapath: clears counters, seeds the
//   index generator, shows each stimulus for MOSTRA_CICLOS cycles, captures
//   and compares plays, counts hits and advances items/rounds to the end.
//   i_clock : clock, rising edge
//   i_reset : asynchronous active-high reset (state -> INICIAL, outputs 0)
//   ctrl    : pj_unidade_controle_if.master (status in, control strobes out)
module pj_unidade_controle
    import pj_unidade_controle_pkg::*;
#(
    parameter int MOSTRA_CICLOS = MOSTRA_CICLOS_DEF
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    pj_unidade_controle_if.master  ctrl
);

    localparam int N_MOSTRA = largura_contador(MOSTRA_CICLOS);

    estado_t r_estado;
    estado_t w_prox;
    logic    r_primeira;
    logic    w_primeira_prox;
    logic    w_fim_mostra;
    logic    w_conta_mostra;

    assign w_conta_mostra = (r_estado == MOSTRA);

    // Held in clear outside MOSTRA so every show period starts from zero.
    pj_unidade_controle_contador_m #(
        .M (MOSTRA_CICLOS),
        .N (N_MOSTRA)
    ) u_timer_mostra (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_zera_s (~w_conta_mostra),
        .i_conta  (w_conta_mostra),
        .o_fim    (w_fim_mostra)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_estado   <= INICIAL;
            r_primeira <= 1'b1;
        end else begin
            r_estado   <= w_prox;
            r_primeira <= w_primeira_prox;
        end
    end

    always_comb begin
        w_prox               = r_estado;
        w_primeira_prox      = r_primeira;
        ctrl.zera_a          = 1'b0;
        ctrl.zera_e          = 1'b0;
        ctrl.zera_r          = 1'b0;
        ctrl.zera_rod        = 1'b0;
        ctrl.zera_indices    = 1'b0;
        ctrl.zera_tempo      = 1'b0;
        ctrl.registra_r      = 1'b0;
        ctrl.registra_indice = 1'b0;
        ctrl.conta_a         = 1'b0;
        ctrl.conta_e         = 1'b0;
        ctrl.conta_rod       = 1'b0;
        ctrl.conta_tempo     = 1'b0;
        ctrl.sel_semente     = 1'b0;
        ctrl.pronto          = 1'b0;

        case (r_estado)
            INICIAL: begin
                if (ctrl.iniciar) w_prox = PREPARA;
            end
            PREPARA: begin
                ctrl.zera_a       = 1'b1;
                ctrl.zera_e       = 1'b1;
                ctrl.zera_r       = 1'b1;
                ctrl.zera_rod     = 1'b1;
                ctrl.zera_indices = 1'b1;
                ctrl.zera_tempo   = 1'b1;
                w_primeira_prox   = 1'b1;
                w_prox            = SEMENTE;
            end
            SEMENTE: begin
                // First round seeds from the free-running timer; later rounds
                // continue from the LFSR's own feedback.
                ctrl.sel_semente = ~r_primeira;
                w_prox           = GERA;
            end
            GERA: begin
                if (ctrl.indices_prontos) w_prox = REG_IDX;
            end
            REG_IDX: begin
                ctrl.registra_indice = 1'b1;
                w_primeira_prox      = 1'b0;
                w_prox               = MOSTRA;
            end
            MOSTRA: begin
                if (w_fim_mostra) w_prox = ESPERA;
            end
            ESPERA: begin
                ctrl.conta_tempo = 1'b1;
                // A play arriving together with the timeout still counts.
                if (ctrl.jogada_feita)  w_prox = REGISTRA;
                else if (ctrl.timeout)  w_prox = PROX_ITEM;
            end
            REGISTRA: begin
                ctrl.registra_r = 1'b1;
                w_prox          = COMPARA;
            end
            COMPARA: begin
                w_prox = ctrl.botao_igual_memoria ? ACERTO : PROX_ITEM;
            end
            ACERTO: begin
                ctrl.conta_a = 1'b1;
                w_prox       = PROX_ITEM;
            end
            PROX_ITEM: begin
                w_prox = ctrl.fim_e ? FIM_RODADA : AVANCA;
            end
            AVANCA: begin
                ctrl.conta_e    = 1'b1;
                ctrl.zera_r     = 1'b1;
                ctrl.zera_tempo = 1'b1;
                w_prox          = MOSTRA;
            end
            FIM_RODADA: begin
                ctrl.conta_rod    = 1'b1;
                ctrl.zera_e       = 1'b1;
                ctrl.zera_r       = 1'b1;
                ctrl.zera_tempo   = 1'b1;
                ctrl.zera_indices = 1'b1;
                w_prox            = CHECA;
            end
            CHECA: begin
                // Round counter has already taken the increment from FIM_RODADA.
                w_prox = ctrl.rodada_igual_final ? FIM : SEMENTE;
            end
            FIM: begin
                ctrl.pronto = 1'b1;
                if (ctrl.iniciar) w_prox = PREPARA;
            end
            default: begin
                w_prox = INICIAL;
            end
        endcase
    end

    assign ctrl.db_estado = r_estado;

endmodule

// File: tb/tb_pj_unidade_controle.sv
module tb_pj_unidade_controle;
    import pj_unidade_controle_pkg::*;

    // Output vector bit order:
    // 13 zera_a, 12 zera_e, 11 zera_r, 10 zera_rod, 9 zera_indices, 8 zera_tempo,
    //  7 registra_r, 6 registra_indice, 5 conta_a, 4 conta_e, 3 conta_rod,
    //  2 conta_tempo, 1 sel_semente, 0 pronto
    localparam logic [13:0] O_NADA = 14'b00000000000000;
    localparam logic [13:0] O_PREP = 14'b11111100000000;
    localparam logic [13:0] O_SEM1 = 14'b00000000000010;
    localparam logic [13:0] O_RIDX = 14'b00000001000000;
    localparam logic [13:0] O_ESP  = 14'b00000000000100;
    localparam logic [13:0] O_REG  = 14'b00000010000000;
    localparam logic [13:0] O_ACE  = 14'b00000000100000;
    localparam logic [13:0] O_AVA  = 14'b00100100010000;
    localparam logic [13:0] O_FRD  = 14'b01101100001000;
    localparam logic [13:0] O_FIM  = 14'b00000000000001;

    typedef struct {
        logic        ini;
        logic        jog;
        logic        bot;
        logic        fim;
        logic        rf;
        logic        idx;
        logic        to;
        logic [3:0]  est;
        logic [13:0] sai;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     n_checks = 0;
    int     n_errors = 0;
    vec_t   vecs[$];

    always #5 clk = ~clk;

    pj_unidade_controle_if u_if ();

    pj_unidade_controle #(
        .MOSTRA_CICLOS (4)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .ctrl    (u_if.master)
    );

    function automatic logic [13:0] saidas();
        return {u_if.zera_a, u_if.zera_e, u_if.zera_r, u_if.zera_rod,
                u_if.zera_indices, u_if.zera_tempo, u_if.registra_r,
                u_if.registra_indice, u_if.conta_a, u_if.conta_e,
                u_if.conta_rod, u_if.conta_tempo, u_if.sel_semente, u_if.pronto};
    endfunction

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nome, act, exp);
        end
    endtask

    task automatic add(input logic ini, jog, bot, fim, rf, idx, to,
                       input logic [3:0] est, input logic [13:0] sai);
        vec_t v;
        v.ini = ini; v.jog = jog; v.bot = bot; v.fim = fim;
        v.rf = rf; v.idx = idx; v.to = to; v.est = est; v.sai = sai;
        vecs.push_back(v);
    endtask

    task automatic aplica(input logic ini, jog, bot, fim, rf, idx, to);
        u_if.iniciar             = ini;
        u_if.jogada_feita        = jog;
        u_if.botao_igual_memoria = bot;
        u_if.fim_e               = fim;
        u_if.rodada_igual_final  = rf;
        u_if.indices_prontos     = idx;
        u_if.timeout             = to;
    endtask

    task automatic passo(input logic [3:0] est, input logic [13:0] sai, input string nome);
        @(posedge clk);
        #1;
        chk({nome, " estado"}, 32'(u_if.db_estado), 32'(est));
        chk({nome, " saidas"}, 32'(saidas()), 32'(sai));
    endtask

    initial begin
        //   ini jog bot fim rf idx to   estado      saidas
        add(1, 0, 0, 0, 0, 0, 0, 4'h1, O_PREP);  // start
        add(0, 0, 0, 0, 0, 0, 0, 4'h2, O_NADA);  // first seed: sel_semente=0
        add(0, 0, 0, 0, 0, 0, 0, 4'h3, O_NADA);
        add(0, 0, 0, 0, 0, 0, 0, 4'h3, O_NADA);  // GERA holds
        add(0, 0, 0, 0, 0, 1, 0, 4'h4, O_RIDX);
        add(0, 0, 0, 0, 0, 0, 0, 4'h5, O_NADA);  // MOSTRA 1/4
        add(0, 1, 0, 0, 0, 0, 0, 4'h5, O_NADA);  // play ignored in MOSTRA
        add(0, 0, 0, 0, 0, 0, 0, 4'h5, O_NADA);
        add(0, 0, 0, 0, 0, 0, 0, 4'h5, O_NADA);  // MOSTRA 4/4
        add(0, 0, 0, 0, 0, 0, 0, 4'h6, O_ESP);
        add(1, 0, 0, 0, 0, 0, 0, 4'h6, O_ESP);   // iniciar ignored
        add(0, 1, 1, 0, 0, 0, 1, 4'h7, O_REG);   // play beats timeout
        add(0, 0, 1, 0, 0, 0, 0, 4'h8, O_NADA);
        add(0, 0, 1, 0, 0, 0, 0, 4'h9, O_ACE);
        add(0, 0, 0, 0, 0, 0, 0, 4'hA, O_NADA);
        add(0, 0, 0, 0, 0, 0, 0, 4'hC, O_AVA);
        add(0, 0, 0, 0, 0, 0, 0, 4'h5, O_NADA);
        add(0, 0, 0, 0, 0, 0, 0, 4'h5, O_NADA);
        add(0, 0, 0, 0, 0, 0, 0, 4'h5, O_NADA);
        add(0, 0, 0, 0, 0, 0, 0, 4'h5, O_NADA);
        add(0, 0, 0, 0, 0, 0, 0, 4'h6, O_ESP);
        add(0, 0, 0, 0, 0, 0, 1, 4'hA, O_NADA);  // miss by timeout
        add(0, 0, 0, 1, 0, 0, 0, 4'hB, O_FRD);
        add(0, 1, 0, 1, 0, 0, 0, 4'hD, O_NADA);
        add(0, 0, 0, 0, 0, 0, 0, 4'h2, O_SEM1);  // later seed: sel_semente=1
        add(0, 0, 0, 0, 0, 0, 0, 4'h3, O_NADA);
        add(0, 0, 0, 0, 0, 1, 0, 4'h4, O_RIDX);
        add(0, 0, 0, 0, 0, 0, 0, 4'h5, O_NADA);
        add(0, 0, 0, 0, 0, 0, 0, 4'h5, O_NADA);
        add(0, 0, 0, 0, 0, 0, 0, 4'h5, O_NADA);
        add(0, 0, 0, 0, 0, 0, 0, 4'h5, O_NADA);
        add(0, 0, 0, 0, 0, 0, 0, 4'h6, O_ESP);
        add(0, 1, 0, 0, 0, 0, 0, 4'h7, O_REG);
        add(0, 0, 0, 0, 0, 0, 0, 4'h8, O_NADA);
        add(0, 0, 0, 0, 0, 0, 0, 4'hA, O_NADA);  // wrong button
        add(0, 0, 0, 1, 1, 0, 0, 4'hB, O_FRD);
        add(0, 0, 0, 1, 1, 0, 0, 4'hD, O_NADA);
        add(0, 0, 0, 0, 1, 0, 0, 4'hE, O_FIM);
        add(0, 0, 0, 0, 0, 0, 0, 4'hE, O_FIM);   // pronto held
        add(1, 0, 0, 0, 0, 0, 0, 4'h1, O_PREP);  // restart
        add(0, 0, 0, 0, 0, 0, 0, 4'h2, O_NADA);  // primeira set again
        add(0, 0, 0, 0, 0, 0, 0, 4'h3, O_NADA);
        add(0, 0, 0, 0, 0, 1, 0, 4'h4, O_RIDX);
        add(0, 0, 0, 0, 0, 0, 0, 4'h5, O_NADA);
        add(0, 0, 0, 0, 0, 0, 0, 4'h5, O_NADA);

        aplica(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset estado", 32'(u_if.db_estado), 32'h0);
        chk("reset saidas", 32'(saidas()), 32'(O_NADA));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            aplica(vecs[i].ini, vecs[i].jog, vecs[i].bot, vecs[i].fim,
                   vecs[i].rf, vecs[i].idx, vecs[i].to);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d estado", i), 32'(u_if.db_estado), 32'(vecs[i].est));
            chk($sformatf("vec%0d saidas", i), 32'(saidas()), 32'(vecs[i].sai));
        end

        // Async reset in the middle of MOSTRA, checked before the next edge.
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mostra estado", 32'(u_if.db_estado), 32'h0);
        chk("rst_mostra saidas", 32'(saidas()), 32'(O_NADA));
        aplica(1, 0, 0, 0, 0, 0, 0);
        passo(4'h0, O_NADA, "rst_segura");
        @(negedge clk);
        rst = 1'b0;
        passo(4'h1, O_PREP, "pos_rst prepara");
        aplica(0, 0, 0, 0, 0, 0, 0);
        passo(4'h2, O_NADA, "pos_rst semente");
        aplica(0, 0, 0, 0, 0, 1, 0);
        passo(4'h3, O_NADA, "pos_rst gera");
        passo(4'h4, O_RIDX, "pos_rst reg_idx");
        aplica(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) passo(4'h5, O_NADA, $sformatf("pos_rst mostra%0d", k));
        passo(4'h6, O_ESP, "pos_rst espera");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
